// File: rtl/counter_pkg.sv
// Shared encodings for the count-stream decoder: FSM states, step classes, moduli.
// Pure declarations; no logic, no latency, no flow control.
package counter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UP     = 3'd1,
    ST_DOWN   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_HOLD    = 3'd0,
    CLS_UP      = 3'd1,
    CLS_DOWN    = 3'd2,
    CLS_JUMP    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } step_cls_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  localparam int MOD16 = 16;
  localparam int MOD10 = 10;

  // Largest legal count value for the selected stream.
  function automatic logic [3:0] top_value(input logic mode);
    return mode ? 4'(MOD10 - 1) : 4'(MOD16 - 1);
  endfunction

  function automatic logic is_err_cls(input logic [2:0] cls);
    return (cls == CLS_JUMP) || (cls == CLS_ILLEGAL);
  endfunction

endpackage

// File: rtl/step_classifier.sv
// Classifies one counter sample against the previous one (hold/up/down/jump/illegal).
// Purely combinational; no flow control.
module step_classifier
  import counter_pkg::*;
(
  input  logic [3:0] prev,
  input  logic [3:0] cur,
  input  logic       mode,
  output logic [2:0] cls,
  output logic       wrap
);

  logic [3:0] w_top;
  logic [3:0] w_up_exp;
  logic [3:0] w_dn_exp;

  always_comb begin
    w_top    = top_value(mode);
    w_up_exp = (prev == w_top) ? 4'd0 : prev + 4'd1;
    w_dn_exp = (prev == 4'd0) ? w_top : prev - 4'd1;
    cls      = CLS_JUMP;
    wrap     = 1'b0;
    if (mode && (cur > w_top)) begin
      cls = CLS_ILLEGAL;
    end else if (cur == prev) begin
      cls = CLS_HOLD;
    end else if (prev > w_top) begin
      // prev left over from the wider stream cannot be a neighbour of anything legal
      cls = CLS_JUMP;
    end else if (cur == w_up_exp) begin
      cls  = CLS_UP;
      wrap = (cur == 4'd0);
    end else if (cur == w_dn_exp) begin
      cls  = CLS_DOWN;
      wrap = (prev == 4'd0);
    end
  end

endmodule

// File: rtl/count_stream_decoder.sv
// Decodes an observed counter stream into step pulses, direction FSM, lock and statistics.
// Flags appear one cycle after the sample; every sample is accepted, no backpressure.
module count_stream_decoder
  import counter_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             mode,
  input  logic [3:0]       count_in,
  output logic             step_up,
  output logic             step_down,
  output logic             step_hold,
  output logic             wrap,
  output logic             err,
  output logic [2:0]       state,
  output logic             locked,
  output logic [3:0]       hold_len,
  output logic [ERR_W-1:0] err_cnt
);

  logic [3:0]       r_prev;
  logic             r_have_prev;
  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_target;
  logic             r_fault_good;
  logic             w_fault_good_nxt;
  logic [2:0]       w_cls;
  logic             w_wrap;
  logic             w_err;
  dir_t             r_dir;
  logic             r_locked;
  logic             r_step_up;
  logic             r_step_down;
  logic             r_step_hold;
  logic             r_wrap;
  logic             r_err;
  logic [3:0]       r_hold_len;
  logic [ERR_W-1:0] r_err_cnt;

  step_classifier u_classifier (
    .prev (r_prev),
    .cur  (count_in),
    .mode (mode),
    .cls  (w_cls),
    .wrap (w_wrap)
  );

  assign w_err = is_err_cls(w_cls);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state      <= ST_IDLE;
      r_fault_good <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fault_good <= w_fault_good_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_fault_good_nxt = r_fault_good;
    case (w_cls)
      CLS_UP:   w_target = ST_UP;
      CLS_DOWN: w_target = ST_DOWN;
      CLS_HOLD: w_target = ST_PAUSED;
      default:  w_target = ST_FAULT;
    endcase
    if (r_have_prev) begin
      if (r_state == ST_FAULT) begin
        // Recovery needs two clean samples in a row; the second picks the exit state.
        if (w_err) begin
          w_fault_good_nxt = 1'b0;
        end else if (!r_fault_good) begin
          w_fault_good_nxt = 1'b1;
        end else begin
          w_state_nxt      = w_target;
          w_fault_good_nxt = 1'b0;
        end
      end else begin
        w_state_nxt      = w_target;
        w_fault_good_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_prev      <= 4'd0;
      r_have_prev <= 1'b0;
      r_step_up   <= 1'b0;
      r_step_down <= 1'b0;
      r_step_hold <= 1'b0;
      r_wrap      <= 1'b0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
      r_dir       <= DIR_NONE;
      r_hold_len  <= 4'd0;
      r_err_cnt   <= '0;
    end else begin
      r_prev      <= count_in;
      r_have_prev <= 1'b1;
      r_step_up   <= r_have_prev && (w_cls == CLS_UP);
      r_step_down <= r_have_prev && (w_cls == CLS_DOWN);
      r_step_hold <= r_have_prev && (w_cls == CLS_HOLD);
      r_wrap      <= r_have_prev && w_wrap;
      r_err       <= r_have_prev && w_err;
      if (r_have_prev) begin
        if (w_cls == CLS_HOLD) begin
          if (r_hold_len != 4'd15) r_hold_len <= r_hold_len + 4'd1;
        end else begin
          r_hold_len <= 4'd0;
        end
        // Holds leave the direction history alone, so lock survives a pause.
        case (w_cls)
          CLS_UP: begin
            if (r_dir == DIR_UP)        r_locked <= 1'b1;
            else if (r_dir == DIR_DOWN) r_locked <= 1'b0;
            r_dir <= DIR_UP;
          end
          CLS_DOWN: begin
            if (r_dir == DIR_DOWN)    r_locked <= 1'b1;
            else if (r_dir == DIR_UP) r_locked <= 1'b0;
            r_dir <= DIR_DOWN;
          end
          CLS_HOLD: begin
            r_dir <= r_dir;
          end
          default: begin
            r_locked <= 1'b0;
            r_dir    <= DIR_NONE;
            if (r_err_cnt != {ERR_W{1'b1}})
              r_err_cnt <= r_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
          end
        endcase
      end
    end
  end

  assign step_up   = r_step_up;
  assign step_down = r_step_down;
  assign step_hold = r_step_hold;
  assign wrap      = r_wrap;
  assign err       = r_err;
  assign state     = r_state;
  assign locked    = r_locked;
  assign hold_len  = r_hold_len;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_count_stream_decoder.sv
// Scoreboard bench for count_stream_decoder: a behavioural model predicts each cycle's outputs.
module tb_count_stream_decoder;

  logic       clk = 1'b0;
  logic       clear;
  logic       mode;
  logic [3:0] count_in;
  logic       step_up, step_down, step_hold, wrap, err, locked;
  logic [2:0] state;
  logic [3:0] hold_len;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  count_stream_decoder #(.ERR_W(8)) dut (
    .clk       (clk),
    .clear     (clear),
    .mode      (mode),
    .count_in  (count_in),
    .step_up   (step_up),
    .step_down (step_down),
    .step_hold (step_hold),
    .wrap      (wrap),
    .err       (err),
    .state     (state),
    .locked    (locked),
    .hold_len  (hold_len),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    bit up; bit dn; bit hold; bit wrap; bit err;
    int state; bit locked; int hold_len; int err_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  int m_prev, m_state, m_dir, m_hold, m_errc;
  bit m_have, m_locked, m_good;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void classify(input int md, input int pv, input int cv,
                                   output int c, output bit w);
    int m;
    m = md ? 10 : 16;
    w = 0;
    if (md != 0 && cv > 9)              c = 3;
    else if (cv == pv)                  c = 0;
    else if (pv >= m)                   c = 3;
    else if (cv == (pv + 1) % m)        begin c = 1; w = (cv == 0); end
    else if (cv == (pv + m - 1) % m)    begin c = 2; w = (pv == 0); end
    else                                c = 3;
  endfunction

  task automatic model_step(input bit clr, input bit md, input int v, output exp_t e);
    int c, tgt;
    bit w;
    e = '{default: 0};
    if (clr) begin
      m_prev = 0; m_have = 0; m_state = 0; m_locked = 0;
      m_dir = 0; m_hold = 0; m_errc = 0; m_good = 0;
    end else if (!m_have) begin
      m_have = 1;
      m_prev = v;
    end else begin
      classify(md, m_prev, v, c, w);
      e.hold = (c == 0); e.up = (c == 1); e.dn = (c == 2); e.err = (c == 3); e.wrap = w;
      m_hold = (c == 0) ? ((m_hold < 15) ? m_hold + 1 : 15) : 0;
      if (c == 3) begin
        if (m_errc < 255) m_errc++;
        m_locked = 0; m_dir = 0;
      end else if (c == 1) begin
        if (m_dir == 1) m_locked = 1; else if (m_dir == -1) m_locked = 0;
        m_dir = 1;
      end else if (c == 2) begin
        if (m_dir == -1) m_locked = 1; else if (m_dir == 1) m_locked = 0;
        m_dir = -1;
      end
      tgt = (c == 0) ? 3 : (c == 1) ? 1 : (c == 2) ? 2 : 4;
      if (m_state == 4) begin
        if (c == 3)       m_good = 0;
        else if (!m_good) m_good = 1;
        else begin m_state = tgt; m_good = 0; end
      end else begin
        m_state = tgt; m_good = 0;
      end
      m_prev = v;
    end
    e.state = m_state; e.locked = m_locked; e.hold_len = m_hold; e.err_cnt = m_errc;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val($sformatf("c%0d_up", cyc),     step_up,   e.up);
      check_val($sformatf("c%0d_down", cyc),   step_down, e.dn);
      check_val($sformatf("c%0d_hold", cyc),   step_hold, e.hold);
      check_val($sformatf("c%0d_wrap", cyc),   wrap,      e.wrap);
      check_val($sformatf("c%0d_err", cyc),    err,       e.err);
      check_val($sformatf("c%0d_state", cyc),  state,     e.state);
      check_val($sformatf("c%0d_locked", cyc), locked,    e.locked);
      check_val($sformatf("c%0d_hlen", cyc),   hold_len,  e.hold_len);
      check_val($sformatf("c%0d_ecnt", cyc),   err_cnt,   e.err_cnt);
    end
  endtask

  task automatic drive(input bit clr, input bit md, input int v);
    exp_t e;
    clear    = clr;
    mode     = md;
    count_in = 4'(v);
    model_step(clr, md, v, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    compare_out();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int last_v, md, r, m;
    clear = 1'b1; mode = 1'b0; count_in = 4'd0;
    drive(1, 0, 0);
    drive(1, 0, 0);
    check_val("rst_state", state, 0);
    check_val("rst_ecnt", err_cnt, 0);

    // Plain count up
    drive(0, 0, 0); drive(0, 0, 1); drive(0, 0, 2);
    check_val("up_locked2", locked, 1);
    drive(0, 0, 3);
    check_val("up_state", state, 1);

    // Mod-16 wrap up
    drive(1, 0, 0);
    drive(0, 0, 14); drive(0, 0, 15); drive(0, 0, 0);
    check_val("w16_wrap", wrap, 1);
    check_val("w16_err", err, 0);
    drive(0, 0, 1);

    // Mod-10 wrap up then reversal
    drive(1, 1, 0);
    drive(0, 1, 8); drive(0, 1, 9); drive(0, 1, 0);
    check_val("w10_up", step_up, 1);
    check_val("w10_wrap", wrap, 1);
    drive(0, 1, 9);
    check_val("w10_down", step_down, 1);
    check_val("w10_state", state, 2);
    check_val("w10_unlock", locked, 0);
    drive(0, 1, 8);

    // Holds then resume
    drive(1, 0, 0);
    drive(0, 0, 5); drive(0, 0, 5); drive(0, 0, 5); drive(0, 0, 5);
    check_val("hold_state", state, 3);
    check_val("hold_len3", hold_len, 3);
    drive(0, 0, 6);
    check_val("hold_resume", state, 1);
    check_val("hold_len0", hold_len, 0);

    // Illegal values, fault and recovery
    drive(1, 1, 0);
    drive(0, 1, 3); drive(0, 1, 12); drive(0, 1, 13); drive(0, 1, 14);
    check_val("flt_state", state, 4);
    check_val("flt_ecnt", err_cnt, 3);
    drive(0, 1, 0); drive(0, 1, 1);
    check_val("flt_stay", state, 4);
    drive(0, 1, 2);
    check_val("flt_exit", state, 1);

    // Clear mid-stream
    drive(1, 0, 0);
    drive(0, 0, 6); drive(0, 0, 7);
    drive(1, 0, 7);
    check_val("clr_state", state, 0);
    check_val("clr_up", step_up, 0);
    drive(0, 0, 7);
    check_val("clr_unclass", step_hold, 0);
    drive(0, 0, 8);
    check_val("clr_step", step_up, 1);

    // Mode switches
    drive(1, 0, 0);
    drive(0, 0, 8); drive(0, 0, 9); drive(0, 1, 0);
    check_val("mode_wrap", wrap, 1);
    drive(1, 0, 0);
    drive(0, 0, 12); drive(0, 0, 13); drive(0, 1, 13);
    check_val("mode_illhold", err, 1);
    drive(0, 1, 5);
    check_val("mode_stale", err, 1);
    drive(0, 1, 6);

    // Down wrap, lock retained across pause
    drive(1, 0, 0);
    drive(0, 0, 1); drive(0, 0, 0); drive(0, 0, 15);
    check_val("dwrap", wrap, 1);
    drive(1, 0, 0);
    drive(0, 0, 1); drive(0, 0, 2); drive(0, 0, 3); drive(0, 0, 3);
    check_val("pause_lock", locked, 1);
    drive(0, 0, 4);
    check_val("pause_relock", locked, 1);
    drive(0, 0, 3);
    check_val("pause_rev", locked, 0);

    // Hold-length saturation
    drive(1, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 4);
    check_val("hlen_sat", hold_len, 15);

    // Error-counter saturation
    drive(1, 0, 0);
    for (int i = 0; i < 300; i++) drive(0, 0, (i % 2 == 0) ? 0 : 8);
    check_val("ecnt_sat", err_cnt, 255);

    // Random walk with occasional mode flips, jumps and clears
    drive(1, 0, 0);
    last_v = 0; md = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) md = 1 - md;
      m = md ? 10 : 16;
      r = $urandom_range(0, 9);
      if (r <= 2)      last_v = (last_v + 1) % m;
      else if (r <= 5) last_v = (last_v + m - 1) % m;
      else if (r == 8) last_v = $urandom_range(0, 15);
      drive((r == 9) && ($urandom_range(0, 3) == 0), md[0], last_v);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
